// File: rtl/seg7_scan_driver_pkg.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver_pkg
//   Shared constants and helpers for the 7-segment scan driver.
//   - SEG_OFF_AL     : active-low "all segments dark" pattern (dp included).
//   - slot_phase_t   : which part of a digit slot a cycle falls in.
//   - hex_to_seg_al  : 16-entry active-low glyph table, bit order
//                      {dp,g,f,e,d,c,b,a}, dp bit left dark (1).
// ----------------------------------------------------------------------------
package seg7_scan_driver_pkg;

  localparam logic [7:0] SEG_OFF_AL = 8'hFF;

  // PH_DEAD: selects and segments forced off to let the previous digit's
  // driver discharge before the next digit is enabled (anti-ghosting).
  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_LIT  = 1'b1
  } slot_phase_t;

  function automatic logic [7:0] hex_to_seg_al(input logic [3:0] value);
    logic [7:0] pattern;
    case (value)
      4'h0:    pattern = 8'hC0;
      4'h1:    pattern = 8'hF9;
      4'h2:    pattern = 8'hA4;
      4'h3:    pattern = 8'hB0;
      4'h4:    pattern = 8'h99;
      4'h5:    pattern = 8'h92;
      4'h6:    pattern = 8'h82;
      4'h7:    pattern = 8'hF8;
      4'h8:    pattern = 8'h80;
      4'h9:    pattern = 8'h90;
      4'hA:    pattern = 8'h88;
      4'hB:    pattern = 8'h83;
      4'hC:    pattern = 8'hC6;
      4'hD:    pattern = 8'hA1;
      4'hE:    pattern = 8'h86;
      default: pattern = 8'h8E;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver_if
//   Bundles the data-source side and the board-pin side of the scan driver.
//   Source -> driver : hex (4 bits per digit, digit 0 rightmost), dp, blank,
//                      lz_en, load (capture strobe).
//   Driver -> pins   : seg {dp,g,f,e,d,c,b,a}, sel (one digit select per
//                      digit), frame_start (first cycle of the digit-0 slot).
//   master modport: the block feeding data in and watching the pins.
//   slave  modport: the scan driver itself.
// ----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] hex;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                lz_en;
  logic                load;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   sel;
  logic                frame_start;

  modport master (
    output hex, dp, blank, lz_en, load,
    input  seg, sel, frame_start
  );

  modport slave (
    input  hex, dp, blank, lz_en, load,
    output seg, sel, frame_start
  );

endinterface

// File: rtl/seg7_scan_driver_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
//   Combinational glyph decoder for one digit, always in active-low form.
//   Ports:
//     hex    in  4  digit value 0..F
//     dp     in  1  decimal point, 1 = lit
//     blank  in  1  1 = whole digit dark, decimal point included
//     seg_al out 8  {dp,g,f,e,d,c,b,a}, 0 = segment lit
//   Output polarity for the board is applied by the caller.
// ----------------------------------------------------------------------------
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg_al
);

  always_comb begin
    seg_al = hex_to_seg_al(hex);
    if (dp) begin
      seg_al[7] = 1'b0;
    end
    // Blank wins over everything, including a lit decimal point.
    if (blank) begin
      seg_al = SEG_OFF_AL;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for a DIGITS-digit common-anode 7-segment display.
//   Display data is loaded into a shadow copy and promoted to the active copy
//   only at the frame boundary, so a scanned frame never mixes two loads.
//   Each digit gets a slot of SLOT_CYCLES clocks; the first DEAD_CYCLES of a
//   slot keep every select and segment dark to suppress ghosting.
//   Optional leading-zero suppression blanks high-order zero digits.
//
//   Ports:
//     clk    in   system clock
//     rst_n  in   synchronous reset, active low
//     bus    slave modport of seg7_scan_driver_if
//              in : hex, dp, blank, lz_en, load
//              out: seg, sel, frame_start (all registered)
//
//   Timing model: cnt_reg/idx_reg hold the slot position of the cycle now on
//   the pins. All output registers are loaded from the *next* position and
//   the *next* active data, so pins and counters change on the same edge and
//   the pin pattern follows the slot map with no extra lag.
// ----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SLOT_CYCLES    = 1024,
  parameter int DEAD_CYCLES    = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [7:0]        SEG_OFF  = SEG_ACTIVE_LOW ? SEG_OFF_AL : ~SEG_OFF_AL;
  localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{SEL_ACTIVE_LOW}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  // Low for the single cycle after reset; the following edge starts the
  // scan at digit 0, cycle 0 instead of advancing.
  logic                run_reg;

  logic [4*DIGITS-1:0] shadow_hex_reg;
  logic [DIGITS-1:0]   shadow_dp_reg;
  logic [DIGITS-1:0]   shadow_blank_reg;
  logic                shadow_lz_reg;
  logic                pending_reg;

  logic [4*DIGITS-1:0] act_hex_reg;
  logic [DIGITS-1:0]   act_dp_reg;
  logic [DIGITS-1:0]   act_blank_reg;
  logic                act_lz_reg;

  logic [7:0]          seg_reg;
  logic [DIGITS-1:0]   sel_reg;
  logic                frame_start_reg;

  // --------------------------------------------------------------------------
  // Slot position of the next cycle
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0] idx_next;
  logic             boundary;

  // Last cycle of the last digit's slot: where shadow data may be promoted.
  assign boundary = run_reg && (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);

  always_comb begin
    cnt_next = '0;
    idx_next = '0;
    if (run_reg) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
        idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
        idx_next = idx_reg;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Active data for the next cycle. A load landing on the boundary cycle
  // bypasses the shadow so the very next frame already shows it.
  // --------------------------------------------------------------------------
  logic [4*DIGITS-1:0] act_hex_next;
  logic [DIGITS-1:0]   act_dp_next;
  logic [DIGITS-1:0]   act_blank_next;
  logic                act_lz_next;

  always_comb begin
    act_hex_next   = act_hex_reg;
    act_dp_next    = act_dp_reg;
    act_blank_next = act_blank_reg;
    act_lz_next    = act_lz_reg;
    if (boundary) begin
      if (bus.load) begin
        act_hex_next   = bus.hex;
        act_dp_next    = bus.dp;
        act_blank_next = bus.blank;
        act_lz_next    = bus.lz_en;
      end else if (pending_reg) begin
        act_hex_next   = shadow_hex_reg;
        act_dp_next    = shadow_dp_reg;
        act_blank_next = shadow_blank_reg;
        act_lz_next    = shadow_lz_reg;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-digit view of the next active data and leading-zero suppression
  // --------------------------------------------------------------------------
  logic [3:0]        digit_hex [DIGITS];
  logic [DIGITS-1:0] suppress;
  logic              leading;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign digit_hex[gi] = act_hex_next[4*gi +: 4];
  end

  // Walk from the most significant digit down; stop at the first digit that
  // shows something (nonzero value or lit dp). Digit 0 is never touched so a
  // value of zero still displays "0".
  always_comb begin
    suppress = '0;
    leading  = act_lz_next;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (leading && (digit_hex[i] == 4'h0) && !act_dp_next[i]) begin
        suppress[i] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Decode of the digit being scanned next
  // --------------------------------------------------------------------------
  logic [3:0] scan_hex;
  logic       scan_dp;
  logic       scan_blank;
  logic [7:0] scan_seg_al;
  logic [7:0] scan_seg;

  assign scan_hex   = digit_hex[idx_next];
  assign scan_dp    = act_dp_next[idx_next];
  assign scan_blank = act_blank_next[idx_next] | suppress[idx_next];

  seg7_decode u_decode (
    .hex    (scan_hex),
    .dp     (scan_dp),
    .blank  (scan_blank),
    .seg_al (scan_seg_al)
  );

  assign scan_seg = SEG_ACTIVE_LOW ? scan_seg_al : ~scan_seg_al;

  // --------------------------------------------------------------------------
  // Slot phase and digit select of the next cycle
  // --------------------------------------------------------------------------
  slot_phase_t       phase_next;
  logic [DIGITS-1:0] onehot_next;

  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign phase_next = PH_LIT;
  end else begin : g_dead
    assign phase_next = (cnt_next < CNT_DEAD) ? PH_DEAD : PH_LIT;
  end

  assign onehot_next = DIGITS'(1) << idx_next;

  // --------------------------------------------------------------------------
  // Sequential state and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg          <= '0;
      idx_reg          <= '0;
      run_reg          <= 1'b0;
      shadow_hex_reg   <= '0;
      shadow_dp_reg    <= '0;
      shadow_blank_reg <= '1;
      shadow_lz_reg    <= 1'b0;
      pending_reg      <= 1'b0;
      act_hex_reg      <= '0;
      act_dp_reg       <= '0;
      act_blank_reg    <= '1;
      act_lz_reg       <= 1'b0;
      seg_reg          <= SEG_OFF;
      sel_reg          <= SEL_OFF;
      frame_start_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      run_reg <= 1'b1;

      if (bus.load) begin
        shadow_hex_reg   <= bus.hex;
        shadow_dp_reg    <= bus.dp;
        shadow_blank_reg <= bus.blank;
        shadow_lz_reg    <= bus.lz_en;
      end

      // The boundary always leaves pending clear: either the shadow was just
      // promoted, or the load went straight to active.
      if (boundary) begin
        pending_reg <= 1'b0;
      end else if (bus.load) begin
        pending_reg <= 1'b1;
      end

      act_hex_reg   <= act_hex_next;
      act_dp_reg    <= act_dp_next;
      act_blank_reg <= act_blank_next;
      act_lz_reg    <= act_lz_next;

      if (phase_next == PH_DEAD) begin
        seg_reg <= SEG_OFF;
        sel_reg <= SEL_OFF;
      end else begin
        seg_reg <= scan_seg;
        sel_reg <= SEL_ACTIVE_LOW ? ~onehot_next : onehot_next;
      end

      frame_start_reg <= (cnt_next == '0) && (idx_next == '0);
    end
  end

  assign bus.seg         = seg_reg;
  assign bus.sel         = sel_reg;
  assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Stimulus drives the driver at the falling edge and, for every cycle, pushes
//   the pin pattern expected in the following cycle into a queue. A monitor
//   pops one entry per rising edge and compares seg, sel and frame_start.
//   The reference works on whole frames: a frame shows the most recent load
//   issued up to and including the last cycle of the previous frame.
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int SLOT   = 8;
  localparam int DEAD   = 2;
  localparam int FRAME  = SLOT * DIGITS;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(
    .DIGITS         (DIGITS),
    .SLOT_CYCLES    (SLOT),
    .DEAD_CYCLES    (DEAD),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
  } frame_t;

  typedef struct {
    int         pos;
    logic [7:0] seg;
    logic [3:0] sel;
    logic       fs;
  } exp_t;

  localparam frame_t DARK = {16'h0000, 4'h0, 4'hF, 1'b0};

  exp_t   exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  int     cur      = -1;   // position of the cycle in progress, -1 = not scanning
  frame_t latest   = DARK; // most recent load
  frame_t shown    = DARK; // data of the frame in progress

  function automatic logic [7:0] glyph(input logic [3:0] v);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[v];
  endfunction

  function automatic logic [7:0] digit_seg(input frame_t fr, input int d);
    logic [15:0] h;
    logic [3:0]  nib;
    bit          all_zero;
    h = fr.hex;
    if (fr.blank[d]) return 8'hFF;
    if (fr.lz && d > 0) begin
      all_zero = 1'b1;
      for (int j = d; j < DIGITS; j++) begin
        nib = 4'(h >> (4 * j));
        if (nib != 4'h0 || fr.dp[j]) all_zero = 1'b0;
      end
      if (all_zero) return 8'hFF;
    end
    nib = 4'(h >> (4 * d));
    return fr.dp[d] ? (glyph(nib) & 8'h7F) : glyph(nib);
  endfunction

  function automatic exp_t model_out(input int p, input frame_t fr);
    exp_t e;
    int   d;
    int   c;
    e.pos = p;
    e.seg = 8'hFF;
    e.sel = 4'hF;
    e.fs  = 1'b0;
    if (p >= 0) begin
      d    = (p / SLOT) % DIGITS;
      c    = p % SLOT;
      e.fs = ((p % FRAME) == 0);
      if (c >= DEAD) begin
        e.sel[d] = 1'b0;
        e.seg    = digit_seg(fr, d);
      end
    end
    return e;
  endfunction

  // One clock of stimulus; the expectation for the next cycle is queued.
  task automatic step(input bit rst_val, input bit ld, input logic [15:0] h,
                      input logic [3:0] d, input logic [3:0] b, input bit lz);
    bit ld_eff;
    @(negedge clk);
    ld_eff    = ld && rst_val && (cur >= 0);
    rst_n     = rst_val;
    bus.load  = ld_eff;
    bus.hex   = h;
    bus.dp    = d;
    bus.blank = b;
    bus.lz_en = lz;
    if (!rst_val) begin
      cur    = -1;
      latest = DARK;
      shown  = DARK;
    end else begin
      if (ld_eff) latest = {h, d, b, lz};
      cur = cur + 1;
      if ((cur % FRAME) == 0) shown = latest;
    end
    exp_q.push_back(model_out(cur, shown));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic run_until(input int phase);
    for (int i = 0; i < 2 * FRAME && (cur % FRAME) != phase; i++) idle(1);
  endtask

  task automatic load(input logic [15:0] h, input logic [3:0] d,
                      input logic [3:0] b, input bit lz);
    step(1'b1, 1'b1, h, d, b, lz);
  endtask

  // Monitor: one queued expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.seg !== e.seg) begin
          failures++;
          $display("FAIL seg pos=%0d got=%02h exp=%02h", e.pos, bus.seg, e.seg);
        end
        checks++;
        if (bus.sel !== e.sel) begin
          failures++;
          $display("FAIL sel pos=%0d got=%01h exp=%01h", e.pos, bus.sel, e.sel);
        end
        checks++;
        if (bus.frame_start !== e.fs) begin
          failures++;
          $display("FAIL frame_start pos=%0d got=%0b exp=%0b", e.pos, bus.frame_start, e.fs);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rh;
    logic [15:0] rmask;
    int          r;
    rst_n     = 1'b0;
    bus.hex   = '0;
    bus.dp    = '0;
    bus.blank = '0;
    bus.lz_en = 1'b0;
    bus.load  = 1'b0;

    // Reset held three cycles, then a dark scan before any load.
    repeat (3) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    idle(40);

    // Plain scan.
    run_until(5);  load(16'h1234, 4'h0, 4'h0, 1'b0); idle(70);
    // Leading-zero suppression, with and without a dp stopping it.
    run_until(10); load(16'h0070, 4'h0, 4'h0, 1'b1); idle(70);
    run_until(10); load(16'h0070, 4'b0100, 4'h0, 1'b1); idle(70);
    // Blank and dp masks.
    run_until(10); load(16'hABCD, 4'b0010, 4'b0101, 1'b0); idle(70);
    // Coherency: early load, mid-frame reload, load on the boundary cycle.
    run_until(3);  load(16'h1111, 4'h0, 4'h0, 1'b0);
    run_until(15); load(16'h2222, 4'h0, 4'h0, 1'b0);
    run_until(31); load(16'h3333, 4'h0, 4'h0, 1'b0);
    idle(70);
    // Mid-scan reset during the digit-2 slot.
    run_until(18); step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    idle(40);
    run_until(7);  load(16'h9F0E, 4'b1000, 4'h0, 1'b1); idle(70);

    // Random traffic: sparse loads, extra loads on boundary cycles, rare resets.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      end else if (r < 12 || ((cur % FRAME) == FRAME - 1 && r < 100)) begin
        rmask = '0;
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 1) == 1) rmask[4*k +: 4] = 4'hF;
        rh = 16'($urandom) & rmask;
        load(rh, 4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom), 1'($urandom));
      end else begin
        idle(1);
      end
    end

    // Let the monitor drain the last expectations.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
